lcd_char_responder: RTL and testbench

Synthesizable HD44780-compatible responder: the display-side end of the character-LCD bus that the calculator's LCD writer drives (`lcd_e`, `lcd_rs`, `lcd_rw`, `lcd_data`).
- Decodes instruction and data transactions and keeps a 2x16 DDRAM shadow plus display-control state.
- Provides a host read port so benches and on-chip checkers can inspect the displayed text.
- Used as the bus-level model in calculator system simulation, and on-chip as a display-content monitor.

---
 rtl/lcd_pkg.sv | 53 +++++
 rtl/lcd_e_edge.sv | 32 +++
 rtl/lcd_char_responder.sv | 160 ++++++++++++++++
 tb/tb_lcd_char_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the character-LCD bus: opcodes, init values,
// character codes, DDRAM geometry and the address-counter step rule.
package lcd_pkg;

  // Instruction opcodes (highest set bit selects the instruction)
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h04;
  localparam logic [7:0] LCD_CMD_DISPLAY = 8'h08;
  localparam logic [7:0] LCD_CMD_SHIFT   = 8'h10;
  localparam logic [7:0] LCD_CMD_FUNC    = 8'h20;
  localparam logic [7:0] LCD_CMD_CGRAM   = 8'h40;
  localparam logic [7:0] LCD_CMD_DDRAM   = 8'h80;

  // Init words issued by the writer
  localparam logic [7:0] LCD_FUNC_8B_2L  = 8'h3C;
  localparam logic [7:0] LCD_DISP_ON     = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC   = 8'h06;

  // Character codes
  localparam logic [7:0] LCD_CH_0        = 8'h30;
  localparam logic [7:0] LCD_CH_PLUS     = 8'h2B;
  localparam logic [7:0] LCD_CH_MINUS    = 8'h2D;
  localparam logic [7:0] LCD_CH_EQ       = 8'h3D;
  localparam logic [7:0] LCD_CH_BLANK    = 8'h20;

  // DDRAM geometry
  localparam logic [6:0] LCD_LINE0_BASE  = 7'h00;
  localparam logic [6:0] LCD_LINE1_BASE  = 7'h40;
  localparam int         LCD_LINE_LEN    = 16;
  localparam int         LCD_CELLS       = 2 * LCD_LINE_LEN;

  typedef enum logic {ST_IDLE, ST_CLEAR} lcd_state_t;

  // Next address-counter value, including the line wrap points
  function automatic logic [6:0] lcd_ac_step(input logic [6:0] ac,
                                             input logic       inc,
                                             input logic       two_line);
    logic [6:0] nxt;
    nxt = inc ? ac + 7'd1 : ac - 7'd1;
    if (two_line) begin
      if (inc && ac == 7'h27)       nxt = LCD_LINE1_BASE;
      else if (inc && ac == 7'h67)  nxt = LCD_LINE0_BASE;
      else if (!inc && ac == 7'h00) nxt = 7'h67;
      else if (!inc && ac == 7'h40) nxt = 7'h27;
    end else begin
      if (inc && ac >= 7'h4F)       nxt = 7'h00;
      else if (!inc && ac == 7'h00) nxt = 7'h4F;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_e_edge.sv
// Synchronizer for the asynchronous bus enable plus edge pulses.
module lcd_e_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic lcd_e,
  output logic e_sync,
  output logic e_rise,
  output logic e_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   e_d;

  // Shift E through the synchronizer and keep one delayed copy for edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      e_d    <= 1'b0;
    end else begin
      sync_q[0] <= lcd_e;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign e_sync = sync_q[SYNC_STAGES-1];
  assign e_rise = e_sync & ~e_d;
  assign e_fall = ~e_sync & e_d;

endmodule

// File: rtl/lcd_char_responder.sv
// Display-side HD44780-compatible responder: decodes bus transactions,
// shadows the 2x16 DDRAM and exposes it through a host read port.
module lcd_char_responder
  import lcd_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CLR_CHAR    = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic [7:0] lcd_dout,
  output logic       lcd_oe,
  input  logic       rd_line,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_char,
  output logic [6:0] cur_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       busy,
  output logic       txn_strobe,
  output logic       proto_err
);

  logic       e_sync, e_rise, e_fall;
  logic       rs_p0, rw_p0;
  logic [7:0] data_p0;
  logic [6:0] ac_q;
  logic       id_q;
  logic [4:0] clr_cnt_q;
  lcd_state_t state_q, state_d;
  logic [7:0] ddram [LCD_CELLS];

  logic       ac_mapped, is_status_rd, drop, clr_start, data_wr;
  logic [4:0] ac_idx;

  lcd_e_edge #(.SYNC_STAGES(SYNC_STAGES)) u_e_edge (
    .clk    (clk),
    .rst    (rst),
    .lcd_e  (lcd_e),
    .e_sync (e_sync),
    .e_rise (e_rise),
    .e_fall (e_fall)
  );

  assign ac_mapped    = (ac_q[5:4] == 2'b00);
  assign ac_idx       = {ac_q[6], ac_q[3:0]};
  assign busy         = (state_q == ST_CLEAR);
  assign is_status_rd = ~rs_p0 & rw_p0;
  assign drop         = e_fall & busy & ~is_status_rd;
  assign clr_start    = e_fall & ~busy & ~rs_p0 & ~rw_p0 & (data_p0 == LCD_CMD_CLEAR);
  assign data_wr      = e_fall & ~busy & rs_p0 & ~rw_p0 & ac_mapped;
  assign cur_addr     = ac_q;

  // Bus capture stage: track RS/RW/data while E is high, last value commits at fall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_p0   <= 1'b0;
      rw_p0   <= 1'b0;
      data_p0 <= '0;
    end else if (e_sync) begin
      rs_p0   <= lcd_rs;
      rw_p0   <= lcd_rw;
      data_p0 <= lcd_data;
    end
  end

  // Clear FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Clear FSM next state: 32 cycles of fill, one cell per cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_start) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_cnt_q == 5'd31) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Committed-transaction decode: address counter, control bits, error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ac_q       <= '0;
      id_q       <= 1'b1;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      two_line   <= 1'b0;
      proto_err  <= 1'b0;
      txn_strobe <= 1'b0;
      clr_cnt_q  <= '0;
    end else begin
      txn_strobe <= e_fall;
      clr_cnt_q  <= busy ? clr_cnt_q + 5'd1 : 5'd0;
      if (drop) begin
        proto_err <= 1'b1;
      end else if (e_fall && !rw_p0 && !rs_p0) begin
        casez (data_p0)
          8'b1???????: ac_q <= data_p0[6:0];
          8'b01??????: ;
          8'b001?????: two_line <= data_p0[3];
          8'b0001????: if (!data_p0[3]) ac_q <= lcd_ac_step(ac_q, data_p0[2], two_line);
          8'b00001???: {disp_on, cursor_on, blink_on} <= data_p0[2:0];
          // Shift-on-entry (bit 0) has no effect on the shadow contents
          8'b000001??: id_q <= data_p0[1];
          8'b0000001?: ac_q <= '0;
          8'b00000001: begin
            ac_q <= '0;
            id_q <= 1'b1;
          end
          default: ;
        endcase
      end else if (e_fall && rs_p0) begin
        ac_q <= lcd_ac_step(ac_q, id_q, two_line);
      end
    end
  end

  // DDRAM shadow: clear fill has priority, data writes only when idle and mapped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LCD_CELLS; i++) ddram[i] <= CLR_CHAR;
    end else if (busy) begin
      ddram[clr_cnt_q] <= CLR_CHAR;
    end else if (data_wr) begin
      ddram[ac_idx] <= data_p0;
    end
  end

  // Host read port, one cycle latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_char <= '0;
    else      rd_char <= ddram[{rd_line, rd_col}];
  end

  // Bus read stage: drive status or cell data while synchronized E is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcd_oe   <= 1'b0;
      lcd_dout <= '0;
    end else begin
      if (e_rise)      lcd_oe <= lcd_rw;
      else if (e_fall) lcd_oe <= 1'b0;
      if (e_sync && lcd_rw)
        lcd_dout <= lcd_rs ? (ac_mapped ? ddram[ac_idx] : CLR_CHAR) : {busy, ac_q};
      else
        lcd_dout <= '0;
    end
  end

endmodule

// File: tb/tb_lcd_char_responder.sv
// Directed bench for lcd_char_responder with hand-computed expectations.
module tb_lcd_char_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data, lcd_dout, rd_char;
  logic       lcd_oe, rd_line;
  logic [3:0] rd_col;
  logic [6:0] cur_addr;
  logic       disp_on, cursor_on, blink_on, two_line, busy, txn_strobe, proto_err;

  int errors = 0;
  int checks = 0;
  int busy_total = 0;
  int busy_snap;

  always #5 clk = ~clk;

  lcd_char_responder #(.SYNC_STAGES(2), .CLR_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .lcd_dout(lcd_dout), .lcd_oe(lcd_oe),
    .rd_line(rd_line), .rd_col(rd_col), .rd_char(rd_char), .cur_addr(cur_addr),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .busy(busy), .txn_strobe(txn_strobe), .proto_err(proto_err)
  );

  always @(negedge clk) if (busy === 1'b1) busy_total++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d; lcd_e = 1'b1;
    repeat (3) @(posedge clk); #1;
    lcd_e = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic bus_read(input string tag, input logic rs, input logic [7:0] exp);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk({tag, "_oe"}, lcd_oe, 1'b1);
    chk({tag, "_dout"}, lcd_dout, exp);
    lcd_e = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk({tag, "_oe_off"}, lcd_oe, 1'b0);
    lcd_rw = 1'b0;
  endtask

  task automatic chk_cell(input string tag, input logic l, input logic [3:0] c, input logic [7:0] exp);
    @(posedge clk); #1;
    rd_line = l; rd_col = c;
    @(posedge clk);
    @(negedge clk);
    chk(tag, rd_char, exp);
  endtask

  // Issue a clear and stop at the negedge right after its commit edge
  task automatic clear_pulse(input string tag);
    @(posedge clk); #1;
    lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_e = 1'b1;
    repeat (3) @(posedge clk); #1;
    lcd_e = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy_pre"}, busy, 1'b0);
    chk({tag, "_strobe_pre"}, txn_strobe, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy_commit"}, busy, 1'b1);
    chk({tag, "_strobe"}, txn_strobe, 1'b1);
  endtask

  initial begin
    logic [7:0] msg [6];
    msg = '{8'h31, 8'h2B, 8'h32, 8'h3D, 8'h30, 8'h33};
    rst = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
    rd_line = 1'b0; rd_col = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ac", cur_addr, 7'h00);
    chk("rst_ctrl", {disp_on, cursor_on, blink_on, two_line}, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_perr", proto_err, 1'b0);
    chk("rst_strobe", txn_strobe, 1'b0);
    chk("rst_oe", lcd_oe, 1'b0);
    chk("rst_dout", lcd_dout, 8'h00);
    chk("rst_rdchar", rd_char, 8'h00);
    @(posedge clk); #1 rst = 1'b1;
    chk_cell("rst_cell", 1'b0, 4'd5, 8'h20);

    // Init sequence
    bus_write(1'b0, 8'h3C);
    bus_write(1'b0, 8'h0C);
    bus_write(1'b0, 8'h06);
    chk("init_two_line", two_line, 1'b1);
    chk("init_disp", {disp_on, cursor_on, blink_on}, 3'b100);
    chk("init_ac", cur_addr, 7'h00);
    chk("init_perr", proto_err, 1'b0);

    // "1+2=03" on line 0
    bus_write(1'b0, 8'h80);
    for (int i = 0; i < 6; i++) bus_write(1'b1, msg[i]);
    chk("msg_ac", cur_addr, 7'h06);
    for (int i = 0; i < 6; i++) chk_cell("msg_cell", 1'b0, i[3:0], msg[i]);

    // 17 writes on line 1: the 17th lands at unmapped 0x50
    bus_write(1'b0, 8'hC0);
    for (int i = 0; i < 17; i++) bus_write(1'b1, 8'h41);
    chk("l1_ac", cur_addr, 7'h51);
    for (int i = 0; i < 16; i++) chk_cell("l1_cell", 1'b1, i[3:0], 8'h41);
    chk_cell("l0_keep0", 1'b0, 4'd0, 8'h31);
    chk_cell("l0_keep5", 1'b0, 4'd5, 8'h33);
    chk_cell("l0_keep6", 1'b0, 4'd6, 8'h20);

    // Status read and data read with AC advance
    bus_read("stat51", 1'b0, 8'h51);
    bus_write(1'b0, 8'h80);
    bus_read("dread", 1'b1, 8'h31);
    chk("dread_ac", cur_addr, 7'h01);

    // Clear, then a data write 5 clk later that must be dropped
    busy_snap = busy_total;
    clear_pulse("clr");
    repeat (5) @(posedge clk);
    bus_write(1'b1, 8'h55);
    chk("clr_perr", proto_err, 1'b1);
    chk("clr_busy_mid", busy, 1'b1);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
    end
    chk("clr_busy_end", busy, 1'b0);
    chk("clr_busy_len", busy_total - busy_snap, 32);
    chk("clr_ac", cur_addr, 7'h00);
    for (int i = 0; i < 32; i++) chk_cell("clr_cell", i[4], i[3:0], 8'h20);

    // Decrement mode: write at 0x00 then wrap to 0x67
    bus_write(1'b0, 8'h04);
    bus_write(1'b0, 8'h80);
    bus_write(1'b1, 8'h35);
    chk_cell("dec_cell", 1'b0, 4'd0, 8'h35);
    chk("dec_ac", cur_addr, 7'h67);
    bus_read("stat67", 1'b0, 8'h67);
    chk("perr_sticky", proto_err, 1'b1);

    // Cursor move instructions with wrap
    bus_write(1'b0, 8'h14);
    chk("mv_right_wrap", cur_addr, 7'h00);
    bus_write(1'b0, 8'h10);
    chk("mv_left_wrap", cur_addr, 7'h67);

    // Reset, fill line 0 in one-line mode, then reset at CLEAR cycle 10
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    chk("rst2_perr", proto_err, 1'b0);
    chk("rst2_two_line", two_line, 1'b0);
    bus_write(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) bus_write(1'b1, 8'h42);
    chk("fill_ac", cur_addr, 7'h10);
    chk_cell("fill_cell15", 1'b0, 4'd15, 8'h42);
    clear_pulse("abort");
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ac", cur_addr, 7'h00);
    chk("abort_rdchar", rd_char, 8'h00);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 32; i++) chk_cell("abort_cell", i[4], i[3:0], 8'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
